// File: rtl/mips_multicycle_core_if.sv
// Unified instruction/data memory port for the multi-cycle MIPS core.
// Valid/ready handshake: a transfer completes on the edge where req and ready are both high.
interface mips_multicycle_core_if #(
  parameter int MEM_AW = 8
);
  logic              mem_req;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-subset core: one shared ALU and one memory port for fetch and data,
// sequenced by BOOT/FETCH/DECODE/EXEC/MEM/WB/HALT.
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MEM_AW   = 8
) (
  input  logic                  clk,
  input  logic                  clr_n,
  mips_multicycle_core_if.master mem,
  output logic [31:0]           pc,
  output logic                  retire,
  output logic                  halted,
  output logic                  illegal
);
  typedef enum logic [2:0] {BOOT, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  state_t      state;
  logic [31:0] ir, a, b, alu_out, mdr, pc4;
  logic [31:0] rf [32];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, wb_dest;
  logic [31:0] simm, alu_res, ctl_pc, wb_data;
  logic        is_legal;

  assign op      = ir[31:26];
  assign rs      = ir[25:21];
  assign rt      = ir[20:16];
  assign rd      = ir[15:11];
  assign funct   = ir[5:0];
  assign simm    = {{16{ir[15]}}, ir[15:0]};
  assign wb_dest = (op == OP_RTYPE) ? rd : rt;
  assign wb_data = (op == OP_LW) ? mdr : alu_out;

  always_comb begin
    is_legal = 1'b0;
    case (op)
      OP_RTYPE: is_legal = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                           (funct == FN_OR)  || (funct == FN_SLT);
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: is_legal = 1'b1;
      default: is_legal = 1'b0;
    endcase
  end

  // Immediate-form ops all share the address adder; R-type selects by funct.
  always_comb begin
    alu_res = a + simm;
    if (op == OP_RTYPE) begin
      case (funct)
        FN_SUB:  alu_res = a - b;
        FN_AND:  alu_res = a & b;
        FN_OR:   alu_res = a | b;
        FN_SLT:  alu_res = {31'b0, ($signed(a) < $signed(b))};
        default: alu_res = a + b;
      endcase
    end
  end

  always_comb begin
    if (op == OP_J)
      ctl_pc = {pc4[31:28], ir[25:0], 2'b00};
    else if (a == b)
      ctl_pc = pc4 + {simm[29:0], 2'b00};
    else
      ctl_pc = pc4;
  end

  // Store retirement waits on the handshake, so retire cannot be a pure state decode.
  assign retire = ((state == EXEC) && ((op == OP_BEQ) || (op == OP_J))) ||
                  (state == WB) ||
                  ((state == MEM) && (op == OP_SW) && mem.mem_ready);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state         <= BOOT;
      pc            <= RESET_PC;
      pc4           <= '0;
      ir            <= '0;
      a             <= '0;
      b             <= '0;
      alu_out       <= '0;
      mdr           <= '0;
      for (int i = 0; i < 32; i++) rf[i] <= '0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      halted        <= 1'b0;
      illegal       <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          mem.mem_req  <= 1'b1;
          mem.mem_we   <= 1'b0;
          mem.mem_addr <= pc[MEM_AW+1:2];
          state        <= FETCH;
        end
        FETCH: if (mem.mem_ready) begin
          ir          <= mem.mem_rdata;
          pc4         <= pc + 32'd4;
          mem.mem_req <= 1'b0;
          state       <= DECODE;
        end
        DECODE: begin
          a <= rf[rs];
          b <= rf[rt];
          if (!is_legal) begin
            halted  <= 1'b1;
            illegal <= 1'b1;
            state   <= HALT;
          end else begin
            state <= EXEC;
          end
        end
        EXEC: begin
          alu_out <= alu_res;
          case (op)
            OP_BEQ, OP_J: begin
              pc           <= ctl_pc;
              mem.mem_req  <= 1'b1;
              mem.mem_we   <= 1'b0;
              mem.mem_addr <= ctl_pc[MEM_AW+1:2];
              state        <= FETCH;
            end
            OP_LW, OP_SW: begin
              if (alu_res[1:0] != 2'b00) begin
                halted  <= 1'b1;
                illegal <= 1'b1;
                state   <= HALT;
              end else begin
                mem.mem_req   <= 1'b1;
                mem.mem_we    <= (op == OP_SW);
                mem.mem_addr  <= alu_res[MEM_AW+1:2];
                mem.mem_wdata <= b;
                state         <= MEM;
              end
            end
            default: state <= WB;
          endcase
        end
        MEM: if (mem.mem_ready) begin
          mem.mem_we <= 1'b0;
          if (op == OP_SW) begin
            pc           <= pc4;
            mem.mem_addr <= pc4[MEM_AW+1:2];
            state        <= FETCH;
          end else begin
            mdr         <= mem.mem_rdata;
            mem.mem_req <= 1'b0;
            state       <= WB;
          end
        end
        WB: begin
          if (wb_dest != 5'd0) rf[wb_dest] <= wb_data;
          pc           <= pc4;
          mem.mem_req  <= 1'b1;
          mem.mem_we   <= 1'b0;
          mem.mem_addr <= pc4[MEM_AW+1:2];
          state        <= FETCH;
        end
        default: state <= HALT;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core: small programs in a unified memory model,
// checked against hand-computed results, cycle counts and handshake behaviour.
module tb_mips_multicycle_core;
  localparam logic [31:0] RST_PC  = 32'h40;
  localparam int          AW      = 8;
  localparam logic [5:0]  OP_ADDI = 6'h08;
  localparam logic [5:0]  OP_LW   = 6'h23;
  localparam logic [5:0]  OP_SW   = 6'h2B;
  localparam logic [5:0]  OP_BEQ  = 6'h04;
  localparam logic [31:0] HALT_W  = 32'hFC00_0000;

  logic clk = 1'b0;
  logic clr_n = 1'b1;
  always #5 clk = ~clk;

  mips_multicycle_core_if #(.MEM_AW(AW)) mif ();
  logic [31:0] pc_o;
  logic        retire, halted, illegal;

  mips_multicycle_core #(.RESET_PC(RST_PC), .MEM_AW(AW)) dut (
    .clk(clk), .clr_n(clr_n), .mem(mif),
    .pc(pc_o), .retire(retire), .halted(halted), .illegal(illegal)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [256];
  logic [31:0] img [256];
  logic        load_req = 1'b0;
  logic        stall_en = 1'b0;
  logic        hold_write = 1'b0;

  assign mif.mem_rdata = mem[mif.mem_addr];

  // Memory array: bulk image load or handshake write.
  always @(posedge clk) begin
    if (load_req) mem <= img;
    else if (mif.mem_req && mif.mem_ready && mif.mem_we) mem[mif.mem_addr] <= mif.mem_wdata;
  end

  // Ready driver, updated just after each rising edge; 0-5 wait states per transfer when stalling.
  logic prev_req = 1'b0;
  logic armed = 1'b0;
  int   wait_left = 0;
  always @(posedge clk) begin
    #1;
    if (!clr_n) begin
      armed = 1'b0;
      prev_req = 1'b0;
      mif.mem_ready = 1'b1;
    end else begin
      if (prev_req && mif.mem_ready) armed = 1'b0;
      if (hold_write && mif.mem_we) mif.mem_ready = 1'b0;
      else if (!stall_en) mif.mem_ready = 1'b1;
      else if (mif.mem_req) begin
        if (!armed) begin
          wait_left = $urandom_range(0, 5);
          armed = 1'b1;
        end
        mif.mem_ready = (wait_left == 0);
        if (wait_left != 0) wait_left--;
      end else mif.mem_ready = 1'b0;
      prev_req = mif.mem_req;
    end
  end

  // Monitor on the falling edge: instruction lengths, stall counts, post-retire pc, bus stability.
  int          cyc = 0, last_ret = 0, win_stalls = 0, stall_total = 0;
  int          req_cnt = 0, stab_err = 0, halt_cyc = 0;
  logic        pend = 1'b0, prev_stall = 1'b0;
  logic [AW-1:0] snap_addr = '0;
  logic        snap_we = 1'b0;
  logic [31:0] snap_wdata = '0;
  int          len_q[$];
  int          stall_q[$];
  logic [31:0] pc_q[$];
  always @(negedge clk) begin
    if (!clr_n) begin
      cyc = 0; last_ret = 0; win_stalls = 0; stall_total = 0;
      req_cnt = 0; stab_err = 0; halt_cyc = 0; pend = 1'b0; prev_stall = 1'b0;
      len_q.delete(); stall_q.delete(); pc_q.delete();
    end else begin
      cyc++;
      if (pend) begin
        pc_q.push_back(pc_o);
        pend = 1'b0;
      end
      if (mif.mem_req) req_cnt++;
      if (prev_stall && mif.mem_req &&
          ({mif.mem_addr, mif.mem_we, mif.mem_wdata} !== {snap_addr, snap_we, snap_wdata}))
        stab_err++;
      prev_stall = mif.mem_req && !mif.mem_ready;
      snap_addr = mif.mem_addr;
      snap_we = mif.mem_we;
      snap_wdata = mif.mem_wdata;
      if (prev_stall) begin
        win_stalls++;
        stall_total++;
      end
      if (halted && halt_cyc == 0) halt_cyc = cyc;
      if (retire) begin
        len_q.push_back(cyc - last_ret);
        stall_q.push_back(win_stalls);
        win_stalls = 0;
        last_ret = cyc;
        pend = 1'b1;
      end
    end
  end

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 32'h0;
  endtask

  // Reset asserted, image loaded, then released just after a rising edge so BOOT fills one cycle.
  task automatic boot_core();
    clr_n = 1'b0;
    load_req = 1'b1;
    @(posedge clk);
    #1 load_req = 1'b0;
    @(posedge clk);
    #2 clr_n = 1'b1;
  endtask

  task automatic wait_halt(input int budget, output bit ok);
    int n = 0;
    while (halted !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (halted === 1'b1);
  endtask

  task automatic test_reset();
    bit ok;
    clear_img();
    img[16] = HALT_W;
    #2 clr_n = 1'b0;
    load_req = 1'b1;
    @(posedge clk);
    #1 load_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({mif.mem_req, mif.mem_we, retire, halted, illegal} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: req/we/retire/halted/illegal=%b required 00000",
               {mif.mem_req, mif.mem_we, retire, halted, illegal});
    end
    checks++;
    if (pc_o !== RST_PC) begin
      failures++;
      $display("[TB] FAIL reset_pc: got %h required %h", pc_o, RST_PC);
    end
    checks++;
    if (mif.mem_addr !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_addr: got %h required 00", mif.mem_addr);
    end
    @(posedge clk);
    #2 clr_n = 1'b1;
    @(negedge clk);
    checks++;
    if (mif.mem_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL boot_idle: mem_req=%b required 0", mif.mem_req);
    end
    @(negedge clk);
    checks++;
    if ({mif.mem_req, mif.mem_we, mif.mem_addr} !== {1'b1, 1'b0, 8'h10}) begin
      failures++;
      $display("[TB] FAIL boot_fetch: req=%b we=%b addr=%h required 1 0 10",
               mif.mem_req, mif.mem_we, mif.mem_addr);
    end
    wait_halt(20, ok);
  endtask

  task automatic test_alu_sequence();
    bit ok;
    int exp_len[12] = '{5, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4};
    logic [31:0] exp_mem[5] = '{32'h2, 32'hFFFF_FFF8, 32'h1, 32'h5, 32'hFFFF_FFFD};
    clear_img();
    img[16] = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd5);
    img[17] = enc_i(OP_ADDI, 5'd0, 5'd2, 16'hFFFD);
    img[18] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
    img[19] = enc_r(5'd2, 5'd1, 5'd4, 6'h22);
    img[20] = enc_r(5'd2, 5'd1, 5'd5, 6'h2A);
    img[21] = enc_r(5'd1, 5'd2, 5'd7, 6'h24);
    img[22] = enc_r(5'd1, 5'd2, 5'd8, 6'h25);
    img[23] = enc_i(OP_SW, 5'd0, 5'd3, 16'd0);
    img[24] = enc_i(OP_SW, 5'd0, 5'd4, 16'd4);
    img[25] = enc_i(OP_SW, 5'd0, 5'd5, 16'd8);
    img[26] = enc_i(OP_SW, 5'd0, 5'd7, 16'd12);
    img[27] = enc_i(OP_SW, 5'd0, 5'd8, 16'd16);
    img[28] = HALT_W;
    boot_core();
    wait_halt(300, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("[TB] FAIL alu_halt: halted=%b required 1", halted);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (mem[i] !== exp_mem[i]) begin
        failures++;
        $display("[TB] FAIL alu_mem[%0d]: got %h required %h", i, mem[i], exp_mem[i]);
      end
    end
    checks++;
    if (len_q.size() != 12) begin
      failures++;
      $display("[TB] FAIL alu_retires: got %0d required 12", len_q.size());
    end
    for (int i = 0; i < 12 && i < len_q.size(); i++) begin
      checks++;
      if (len_q[i] != exp_len[i]) begin
        failures++;
        $display("[TB] FAIL alu_cycles[%0d]: got %0d required %0d", i, len_q[i], exp_len[i]);
      end
    end
    checks++;
    if ({pc_o, illegal} !== {32'h70, 1'b1}) begin
      failures++;
      $display("[TB] FAIL alu_end: pc=%h illegal=%b required 00000070 1", pc_o, illegal);
    end
  endtask

  task automatic test_branch_jump();
    bit ok;
    int n;
    int exp_len[4] = '{4, 4, 3, 3};
    logic [31:0] exp_pc[4] = '{32'h4C, 32'h50, 32'h40, 32'h44};
    clear_img();
    img[16] = enc_i(OP_BEQ, 5'd0, 5'd0, 16'hFFFF);
    boot_core();
    n = 0;
    while (pc_q.size() < 3 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (pc_q.size() < 3) begin
      failures++;
      $display("[TB] FAIL loop_retires: got %0d required 3", pc_q.size());
    end
    for (int i = 0; i < 3 && i < pc_q.size(); i++) begin
      checks++;
      if ({pc_q[i], len_q[i]} !== {32'h40, (i == 0) ? 32'd4 : 32'd3}) begin
        failures++;
        $display("[TB] FAIL loop[%0d]: pc=%h cycles=%0d required pc=00000040 cycles=%0d",
                 i, pc_q[i], len_q[i], (i == 0) ? 4 : 3);
      end
    end

    clear_img();
    img[16] = enc_i(OP_BEQ, 5'd3, 5'd0, 16'd2);
    img[17] = HALT_W;
    img[18] = HALT_W;
    img[19] = enc_i(OP_ADDI, 5'd0, 5'd3, 16'd1);
    img[20] = {6'h02, 26'h000_0010};
    img[21] = HALT_W;
    boot_core();
    wait_halt(100, ok);
    checks++;
    if (!ok || pc_q.size() != 4) begin
      failures++;
      $display("[TB] FAIL bj_flow: halted=%b retires=%0d required 1 4", halted, pc_q.size());
    end
    for (int i = 0; i < 4 && i < pc_q.size(); i++) begin
      checks++;
      if ({pc_q[i], len_q[i]} !== {exp_pc[i], exp_len[i]}) begin
        failures++;
        $display("[TB] FAIL bj[%0d]: pc=%h cycles=%0d required pc=%h cycles=%0d",
                 i, pc_q[i], len_q[i], exp_pc[i], exp_len[i]);
      end
    end
  endtask

  task automatic test_wait_states();
    bit ok;
    int base[4] = '{5, 4, 5, 4};
    clear_img();
    img[16] = enc_i(OP_ADDI, 5'd0, 5'd1, 16'h1234);
    img[17] = enc_i(OP_SW, 5'd0, 5'd1, 16'd32);
    img[18] = enc_i(OP_LW, 5'd0, 5'd6, 16'd32);
    img[19] = enc_i(OP_SW, 5'd0, 5'd6, 16'd36);
    img[20] = HALT_W;
    stall_en = 1'b1;
    boot_core();
    wait_halt(400, ok);
    stall_en = 1'b0;
    checks++;
    if (!ok || len_q.size() != 4) begin
      failures++;
      $display("[TB] FAIL ws_flow: halted=%b retires=%0d required 1 4", halted, len_q.size());
    end
    checks++;
    if ({mem[8], mem[9]} !== {32'h1234, 32'h1234}) begin
      failures++;
      $display("[TB] FAIL ws_data: w8=%h w9=%h required 00001234 00001234", mem[8], mem[9]);
    end
    for (int i = 0; i < 4 && i < len_q.size(); i++) begin
      checks++;
      if (len_q[i] != base[i] + stall_q[i]) begin
        failures++;
        $display("[TB] FAIL ws_cycles[%0d]: got %0d required %0d", i, len_q[i], base[i] + stall_q[i]);
      end
    end
    checks++;
    if (stab_err != 0 || stall_total == 0) begin
      failures++;
      $display("[TB] FAIL ws_stable: unstable_cycles=%0d stalls=%0d required 0 and >0",
               stab_err, stall_total);
    end
  endtask

  task automatic test_faults();
    bit ok;
    int rc;
    clear_img();
    img[16] = HALT_W;
    boot_core();
    wait_halt(40, ok);
    rc = req_cnt;
    repeat (10) @(negedge clk);
    checks++;
    if ({ok, illegal, pc_o} !== {1'b1, 1'b1, 32'h40}) begin
      failures++;
      $display("[TB] FAIL bad_op: halted=%b illegal=%b pc=%h required 1 1 00000040", ok, illegal, pc_o);
    end
    checks++;
    if (halt_cyc != 4 || req_cnt != rc || len_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL bad_op_timing: halt_cycle=%0d extra_req=%0d retires=%0d required 4 0 0",
               halt_cyc, req_cnt - rc, len_q.size());
    end

    clear_img();
    img[16] = enc_i(OP_LW, 5'd0, 5'd1, 16'd2);
    boot_core();
    wait_halt(40, ok);
    repeat (5) @(negedge clk);
    checks++;
    if ({ok, illegal, pc_o} !== {1'b1, 1'b1, 32'h40}) begin
      failures++;
      $display("[TB] FAIL misalign: halted=%b illegal=%b pc=%h required 1 1 00000040", ok, illegal, pc_o);
    end
    checks++;
    if (halt_cyc != 5 || req_cnt != 1) begin
      failures++;
      $display("[TB] FAIL misalign_timing: halt_cycle=%0d req_cycles=%0d required 5 1", halt_cyc, req_cnt);
    end

    clear_img();
    img[0] = 32'hDEAD_BEEF;
    img[1] = 32'hDEAD_BEEF;
    img[16] = enc_i(OP_ADDI, 5'd0, 5'd0, 16'd7);
    img[17] = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd3);
    img[18] = enc_r(5'd1, 5'd1, 5'd0, 6'h20);
    img[19] = enc_i(OP_SW, 5'd0, 5'd0, 16'd0);
    img[20] = enc_i(OP_SW, 5'd0, 5'd1, 16'd4);
    img[21] = HALT_W;
    boot_core();
    wait_halt(100, ok);
    checks++;
    if ({mem[0], mem[1]} !== {32'h0, 32'h3}) begin
      failures++;
      $display("[TB] FAIL reg_zero: w0=%h w1=%h required 00000000 00000003", mem[0], mem[1]);
    end
  endtask

  task automatic test_mid_reset();
    int n;
    clear_img();
    img[0] = 32'h0000_0055;
    img[16] = enc_i(OP_ADDI, 5'd0, 5'd1, 16'd9);
    img[17] = enc_i(OP_SW, 5'd0, 5'd1, 16'd0);
    img[18] = HALT_W;
    hold_write = 1'b1;
    boot_core();
    n = 0;
    while (!(mif.mem_req === 1'b1 && mif.mem_we === 1'b1) && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({mif.mem_req, mif.mem_we, mif.mem_wdata} !== {1'b1, 1'b1, 32'h9}) begin
      failures++;
      $display("[TB] FAIL stalled_write: req=%b we=%b wdata=%h required 1 1 00000009",
               mif.mem_req, mif.mem_we, mif.mem_wdata);
    end
    #2 clr_n = 1'b0;
    #1;
    checks++;
    if ({mif.mem_req, mif.mem_we} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL async_drop: req=%b we=%b required 0 0", mif.mem_req, mif.mem_we);
    end
    hold_write = 1'b0;
    @(negedge clk);
    checks++;
    if (mem[0] !== 32'h55) begin
      failures++;
      $display("[TB] FAIL abandoned_write: w0=%h required 00000055", mem[0]);
    end
    @(posedge clk);
    #2 clr_n = 1'b1;
    @(negedge clk);
    checks++;
    if (mif.mem_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reboot_idle: mem_req=%b required 0", mif.mem_req);
    end
    @(negedge clk);
    checks++;
    if ({mif.mem_req, mif.mem_we, mif.mem_addr, pc_o} !== {1'b1, 1'b0, 8'h10, 32'h40}) begin
      failures++;
      $display("[TB] FAIL reboot_fetch: req=%b we=%b addr=%h pc=%h required 1 0 10 00000040",
               mif.mem_req, mif.mem_we, mif.mem_addr, pc_o);
    end
  endtask

  initial begin
    $display("[TB] starting mips_multicycle_core directed tests");
    test_reset();
    test_alu_sequence();
    test_branch_jump();
    test_wait_states();
    test_faults();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_core.md
# mips_multicycle_core

Multi-cycle successor to the team's single-cycle MIPS-subset datapath. It executes the same instruction subset plus `addi` and `j` through a state machine that shares one ALU and one external memory port for both instruction fetch and data access. The memory port uses a valid/ready handshake with unbounded wait states. The PC reset vector and memory address width are parameters. The block sits between the top-level clock/reset and a single unified instruction/data memory.

## Interface
- `RESET_PC`, default 32'h0000_0000: byte address of the first fetch after reset; must be word aligned.
- `MEM_AW`, default 8: word-address width of the memory port; byte-address bits [MEM_AW+1:2] are driven, upper bits are dropped.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `clr_n`  in  1  reset, asynchronous and active-low.
- `mem_req`  out  1  memory transaction request (fetch or data).
- `mem_we`  out  1  1 = write (sw), 0 = read; valid only while `mem_req` = 1.
- `mem_addr`  out  MEM_AW  word address.
- `mem_wdata`  out  32  store data.
- `mem_ready`  in  1  transaction completes on the rising edge where `mem_req` and `mem_ready` are both 1.
- `mem_rdata`  in  32  read data; sampled on the completing edge.
- `pc`  out  32  byte address of the current instruction.
- `retire`  out  1  one-cycle pulse in the final state of each executed instruction.
- `halted`  out  1  core is in HALT.
- `illegal`  out  1  HALT was entered on an unsupported opcode/funct or a misaligned access.

## Operation
- States are BOOT, FETCH, DECODE, EXEC, MEM, WB, HALT.
- Reset values:
  - state = BOOT, `pc` = RESET_PC.
  - All 32 registers = 0; IR, A, B and ALUOut = 0.
  - `mem_req`, `mem_we`, `retire`, `halted`, `illegal` = 0.
- Supported instructions:
  - R-type (op 0x00) with funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A.
  - addi 0x08, lw 0x23, sw 0x2B, beq 0x04, j 0x02.
  - Anything else goes to HALT with `illegal` = 1.
- BOOT: one idle cycle, then FETCH.
- FETCH: `mem_req` = 1, `mem_we` = 0, `mem_addr` = `pc[MEM_AW+1:2]`. Stays in FETCH until `mem_ready`. On completion, IR <= `mem_rdata`, PC4 <= `pc` + 4, go to DECODE.
- DECODE:
  - A <= rf[rs], B <= rf[rt].
  - Illegal encodings go to HALT.
  - Otherwise go to EXEC.
- EXEC:
  - R-type: ALUOut <= A op B, then WB.
  - addi, lw, sw: ALUOut <= A + sext(imm16).
    - If the address is misaligned (ALUOut[1:0] ≠ 0), lw/sw go to HALT with `illegal` = 1.
    - Otherwise lw/sw go to MEM, and addi goes to WB.
  - beq: `pc` <= (A == B) ? PC4 + (sext(imm16) << 2) : PC4. Pulse `retire`, go to FETCH.
  - j: `pc` <= {PC4[31:28], imm26, 2'b00}. Pulse `retire`, go to FETCH.
- MEM: `mem_req` = 1, `mem_addr` = ALUOut[MEM_AW+1:2].
  - sw: `mem_we` = 1, `mem_wdata` = B. On completion, `pc` <= PC4, pulse `retire`, go to FETCH.
  - lw: `mem_we` = 0. On completion, MDR <= `mem_rdata`, go to WB.
- WB:
  - Destination register: rd for R-type, rt for addi and lw.
  - Write data: ALUOut, or MDR for lw.
  - `pc` <= PC4, pulse `retire`, go to FETCH.
- Arithmetic:
  - 32-bit two's complement; add/sub/addi wrap with no overflow trap.
  - slt is a signed compare, result 0 or 1.
  - `pc` wraps modulo 2^32.
- Register 0: reads always return 0, and writes to it are discarded.
- HALT:
  - Terminal state; `mem_req` = 0, `halted` = 1.
  - `illegal` is held once set.
  - `pc` holds the address of the offending or last instruction.
  - Only reset exits HALT.

## Timing
- Cycle counts with zero-wait memory (`mem_ready` held at 1):
  - beq, j: 3 cycles.
  - R-type, addi, sw: 4 cycles.
  - lw: 5 cycles.
- Each cycle that `mem_ready` is low in FETCH or MEM adds exactly one cycle.
- While `mem_req` = 1 and `mem_ready` = 0, `mem_we`, `mem_addr` and `mem_wdata` must be held stable.
- `mem_ready` is ignored while `mem_req` = 0.
- `mem_req` is decoded from the state register only; it never depends combinationally on `mem_ready`.
- `retire` is high for exactly one cycle per instruction, aligned with the cycle in which `pc` is updated (the new value is visible next cycle).
- The register-file write in WB is visible to the DECODE of the next instruction (back-to-back dependency needs no forwarding).
- Reset asserted mid-transaction: `mem_req` drops immediately (asynchronously) and the transaction is abandoned. After release, the first FETCH of RESET_PC starts 2 edges later (BOOT, then FETCH).

## Test plan
- Reset/boot: RESET_PC = 32'h40, zero-wait memory, release `clr_n`. Required: `mem_req` = 0 for the first cycle, then a fetch at `mem_addr` = 8'h10. All outputs are 0 during reset.
- ALU sequence:
  - Program: addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; sub $4,$2,$1; slt $5,$2,$1; and/or; sw $3,0($0).
  - Required: the store writes 32'h2 to word 0.
  - Register checks: $4 = 32'hFFFF_FFF8, $5 = 1.
  - Each instruction takes the cycle count listed under Timing.
- Branch/jump:
  - beq taken with offset −1 loops to itself.
  - beq not taken advances by 4.
  - j 0x0000010 sets `pc` = 32'h40.
  - Each takes 3 cycles with a single `retire` pulse.
- Wait states: random 0–5 cycle `mem_ready` stalls on fetch, lw and sw.
  - Address, `mem_we` and `mem_wdata` stay stable throughout each stall.
  - lw $6 returns the stored value.
  - Cycle count grows by exactly the stall count.
- Faults:
  - Opcode 0x3F: `halted` = 1 and `illegal` = 1 after DECODE, `pc` unchanged, no further `mem_req`.
  - lw at byte address 2: same response, entering HALT from EXEC.
  - Write to $0 then read it back: value is 0.
- Mid-operation reset: assert `clr_n` = 0 during a stalled MEM write. Required: `mem_req` falls in the same cycle, and the refetch from RESET_PC matches the boot scenario.
